// File: rtl/rls_pkg.sv
// Shared definitions for the RLS datapath stages.
//   state_t : accumulator control states (ACCUM gathers terms, HOLD presents a result)
//   NBITS   : default datapath width of products and results
//   clog2   : ceiling log2, used for counter widths and parameter checks
package rls_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int NBITS = 32;

  // Ceiling log2; clog2(1) is 0 so a single-term vector needs no count bits.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rls_sat_narrow.sv
// Combinational narrowing of a wide signed value to OutW bits with saturation.
//   i_val : signed input, InW bits (InW >= OutW)
//   o_val : input clipped to the signed OutW range, else truncated
//   o_sat : 1 when clipping took place
module rls_sat_narrow
  import rls_pkg::*;
#(
  parameter int InW  = 36,
  parameter int OutW = NBITS
) (
  input  logic signed [InW-1:0]  i_val,
  output logic        [OutW-1:0] o_val,
  output logic                   o_sat
);

  // The value fits when every bit from the MSB down to the OutW sign bit agrees.
  logic [InW-OutW:0] w_top;
  logic              w_fits;

  assign w_top  = i_val[InW-1:OutW-1];
  assign w_fits = (&w_top) | ~(|w_top);

  always_comb begin
    o_val = i_val[OutW-1:0];
    o_sat = 1'b0;
    if (!w_fits) begin
      o_sat = 1'b1;
      o_val = i_val[InW-1] ? {1'b1, {(OutW-1){1'b0}}} : {1'b0, {(OutW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/rls_dot_accumulator.sv
// Streaming inner-product accumulator placed after the RLS multiplier.
// Sums VecLen signed products per result and offers it on a valid/ready port.
//   clk, rst_n             : clock and synchronous active-low reset
//   clear                  : flush partial sum and pending result
//   prod/prod_valid/prod_ready : product input handshake
//   sum/sum_sat/sum_valid/sum_ready : saturated result output handshake
module rls_dot_accumulator
  import rls_pkg::*;
#(
  parameter int nBits     = NBITS,
  parameter int VecLen    = 4,
  parameter int GuardBits = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic signed [nBits-1:0] prod,
  input  logic                    prod_valid,
  output logic                    prod_ready,
  output logic        [nBits-1:0] sum,
  output logic                    sum_sat,
  output logic                    sum_valid,
  input  logic                    sum_ready
);

  localparam int AccW = nBits + GuardBits;
  localparam int CntW = (clog2(VecLen) < 1) ? 1 : clog2(VecLen);

  // Guard bits must cover the growth of VecLen terms or the accumulator could wrap.
  generate
    if (VecLen < 1 || GuardBits < clog2(VecLen)) begin : g_bad_params
      $error("rls_dot_accumulator: need VecLen >= 1 and GuardBits >= clog2(VecLen)");
    end
  endgenerate

  state_t                 r_state;
  logic signed [AccW-1:0] r_acc;
  logic        [CntW-1:0] r_cnt;
  logic        [nBits-1:0] r_sum;
  logic                   r_sum_sat;
  logic                   r_sum_valid;

  logic signed [AccW-1:0] w_ext;
  logic signed [AccW-1:0] w_total;
  logic        [nBits-1:0] w_narrow;
  logic                   w_narrow_sat;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_take;

  assign w_ext    = AccW'(prod);
  assign w_total  = r_acc + w_ext;
  assign w_last   = (r_cnt == CntW'(VecLen - 1));
  assign w_accept = prod_valid && prod_ready;
  assign w_take   = r_sum_valid && sum_ready;

  // In HOLD a new beat may only enter when the pending result leaves in the
  // same cycle, which keeps back-to-back vectors free of bubbles.
  assign prod_ready = (r_state == ACCUM) ? 1'b1 : sum_ready;

  rls_sat_narrow #(
    .InW  (AccW),
    .OutW (nBits)
  ) u_sat (
    .i_val (w_total),
    .o_val (w_narrow),
    .o_sat (w_narrow_sat)
  );

  // Accumulate/hold control. A completing beat always loads a fresh result
  // (replacing one being taken); otherwise a taken result drops valid and
  // returns to ACCUM while any non-final beat is still accumulated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_sum_sat   <= 1'b0;
      r_sum_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum_valid <= 1'b0;
    end else if (w_accept && w_last) begin
      r_sum       <= w_narrow;
      r_sum_sat   <= w_narrow_sat;
      r_sum_valid <= 1'b1;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_state     <= HOLD;
    end else begin
      if (w_accept) begin
        r_acc <= w_total;
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_take) begin
        r_sum_valid <= 1'b0;
        r_state     <= ACCUM;
      end
    end
  end

  assign sum       = r_sum;
  assign sum_sat   = r_sum_sat;
  assign sum_valid = r_sum_valid;

endmodule

// File: tb/tb_rls_dot_accumulator.sv
// Self-checking bench for rls_dot_accumulator (nBits=32, VecLen=4).
// Expected results are queued when stimulus is issued; a monitor pops and
// compares them whenever the DUT hands a result over.
module tb_rls_dot_accumulator;

  logic        clk;
  logic        rstN;
  logic        clearIn;
  logic [31:0] prodIn;
  logic        prodValid;
  logic        prodReady;
  logic [31:0] sumOut;
  logic        sumSat;
  logic        sumValid;
  logic        sumReady;

  typedef struct packed {
    logic [31:0] value;
    logic        sat;
  } expect_t;

  expect_t sbQ[$];
  int      total = 0;
  int      bad   = 0;

  rls_dot_accumulator #(
    .nBits     (32),
    .VecLen    (4),
    .GuardBits (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .clear      (clearIn),
    .prod       (prodIn),
    .prod_valid (prodValid),
    .prod_ready (prodReady),
    .sum        (sumOut),
    .sum_sat    (sumSat),
    .sum_valid  (sumValid),
    .sum_ready  (sumReady)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, required);
    end
  endtask

  // Drive one beat (or idle) and advance past the next rising edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] value);
    prodValid = valid;
    prodIn    = value;
    @(posedge clk);
    #1;
  endtask

  task automatic sendVector(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    applyStimulus(1'b1, a);
    applyStimulus(1'b1, b);
    applyStimulus(1'b1, c);
    applyStimulus(1'b1, d);
    prodValid = 1'b0;
  endtask

  // Let the pending result be taken for one cycle, then close the output again.
  task automatic drainResult();
    sumReady = 1'b1;
    applyStimulus(1'b0, 32'h0);
    checkOutput("valid_after_take", {31'b0, sumValid}, 32'd0);
    sumReady = 1'b0;
  endtask

  // Monitor: every handed-over result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstN && !clearIn && sumValid && sumReady) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got %h required none", sumOut);
      end else begin
        expect_t e;
        e = sbQ.pop_front();
        checkOutput("sum", sumOut, e.value);
        checkOutput("sum_sat", {31'b0, sumSat}, {31'b0, e.sat});
      end
    end
  end

  // Directed sequence: reset, basic, signed, saturation, streaming, flush.
  initial begin
    logic [31:0] pat[8];
    rstN      = 1'b0;
    clearIn   = 1'b0;
    prodValid = 1'b1;
    prodIn    = 32'd5;
    sumReady  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_valid", {31'b0, sumValid}, 32'd0);
      checkOutput("reset_sum", sumOut, 32'd0);
      checkOutput("reset_sat", {31'b0, sumSat}, 32'd0);
    end
    rstN      = 1'b1;
    prodValid = 1'b0;
    checkOutput("ready_after_reset", {31'b0, prodReady}, 32'd1);

    // Basic sum held while downstream stalls.
    sbQ.push_back('{32'd10, 1'b0});
    sendVector(32'd1, 32'd2, 32'd3, 32'd4);
    checkOutput("basic_valid", {31'b0, sumValid}, 32'd1);
    checkOutput("basic_sum", sumOut, 32'd10);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_ready", {31'b0, prodReady}, 32'd0);
      checkOutput("hold_sum", sumOut, 32'd10);
      checkOutput("hold_valid", {31'b0, sumValid}, 32'd1);
      applyStimulus(1'b0, 32'h0);
    end
    drainResult();

    // Signed terms: -5 + 3 - 7 + 2 = -7.
    sbQ.push_back('{32'hFFFF_FFF9, 1'b0});
    sendVector(32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFF9, 32'd2);
    drainResult();

    // Positive and negative saturation.
    sbQ.push_back('{32'h7FFF_FFFF, 1'b1});
    sendVector(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    drainResult();
    sbQ.push_back('{32'h8000_0000, 1'b1});
    sendVector(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    drainResult();

    // Streaming: results 10 and 26, each valid for exactly one cycle.
    sumReady = 1'b1;
    sbQ.push_back('{32'd10, 1'b0});
    sbQ.push_back('{32'd26, 1'b0});
    for (int k = 0; k < 8; k++) pat[k] = 32'(k + 1);
    for (int k = 0; k < 8; k++) begin
      prodValid = 1'b1;
      prodIn    = pat[k];
      #1;
      checkOutput("stream_ready", {31'b0, prodReady}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("stream_valid", {31'b0, sumValid}, (k == 3 || k == 7) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 32'h0);
    checkOutput("stream_end_valid", {31'b0, sumValid}, 32'd0);
    sumReady = 1'b0;

    // Flush with clear: the beat of 100 in the clear cycle is dropped.
    applyStimulus(1'b1, 32'd7);
    applyStimulus(1'b1, 32'd9);
    clearIn   = 1'b1;
    prodValid = 1'b1;
    prodIn    = 32'd100;
    #1;
    checkOutput("clear_ready", {31'b0, prodReady}, 32'd1);
    @(posedge clk);
    #1;
    clearIn = 1'b0;
    checkOutput("clear_valid", {31'b0, sumValid}, 32'd0);
    checkOutput("clear_keeps_sum", sumOut, 32'd26);
    sbQ.push_back('{32'd4, 1'b0});
    sendVector(32'd1, 32'd1, 32'd1, 32'd1);
    checkOutput("flush_sum", sumOut, 32'd4);
    drainResult();

    // Same flush using a one-cycle reset.
    applyStimulus(1'b1, 32'd7);
    applyStimulus(1'b1, 32'd9);
    rstN      = 1'b0;
    prodValid = 1'b1;
    prodIn    = 32'd100;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    checkOutput("rst_flush_valid", {31'b0, sumValid}, 32'd0);
    checkOutput("rst_flush_sum", sumOut, 32'd0);
    sbQ.push_back('{32'd4, 1'b0});
    sendVector(32'd1, 32'd1, 32'd1, 32'd1);
    checkOutput("rst_flush_sum4", sumOut, 32'd4);
    drainResult();

    applyStimulus(1'b0, 32'h0);
    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rls_dot_accumulator.md
Name: rls_dot_accumulator

Overview:
- Streaming accumulator that sits directly downstream of the RLS multiplier stage. It consumes one nBits signed product per accepted beat.
- It sums VecLen consecutive products into one inner-product result (phi'·w, phi'·P·phi terms) and presents it on a registered valid/ready output to the next RLS update stage.
- It provides the pipeline register and flow control that the combinational multiplier lacks.

Parameters:
- nBits, 32: width of products and of the result; two's complement.
- VecLen, 4: number of products summed per result; must be at least 1.
- GuardBits, 4: extra internal accumulator bits; must be at least clog2(VecLen).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous flush of the partial sum and of any pending result.
- prod  in  nBits  signed product from the multiplier.
- prod_valid  in  1  prod is valid this cycle.
- prod_ready  out  1  accumulator accepts prod this cycle.
- sum  out  nBits  saturated inner-product result.
- sum_sat  out  1  sum was clipped, qualified by sum_valid.
- sum_valid  out  1  sum and sum_sat valid; held until accepted.
- sum_ready  in  1  downstream accepts the result.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is synchronous and active-low.
  - Priority per edge: rst_n low, then clear, then normal operation.
- Reset values:
  - acc=0, cnt=0, state=ACCUM.
  - sum=0, sum_sat=0, sum_valid=0.
  - prod_ready=1 in the first cycle after reset release.
- Internal width: acc is nBits+GuardBits signed. Each accepted prod is sign-extended before it is added. acc cannot wrap, given the parameter constraint.
- Handshake:
  - A beat is accepted when prod_valid && prod_ready.
  - A result is taken when sum_valid && sum_ready.
  - sum and sum_sat are stable while sum_valid=1 && sum_ready=0.
- States:
  - ACCUM:
    - prod_ready=1.
    - On accept with cnt<VecLen-1: acc += prod, cnt++.
    - On accept with cnt==VecLen-1: register sat(acc+prod) into sum, set sum_sat, sum_valid=1, acc=0, cnt=0, go to HOLD.
  - HOLD:
    - prod_ready = sum_ready (combinational). This gives zero-bubble back-to-back results.
    - If sum_ready=1 and there is no completing accept: sum_valid goes to 0 and the state returns to ACCUM. Any beat accepted in that cycle is accumulated normally.
    - If sum_ready=1 and a completing accept occurs in the same cycle (always the case for VecLen=1): the new result replaces the old one, sum_valid stays 1 and the state stays HOLD.
- Latency: sum_valid rises on the edge after the accept of the last term, i.e. 1 cycle. Throughput is one product per cycle.
- Saturation: the full-width total is compared with signed nBits limits.
  - Above 2^(nBits-1)-1: sum=0x7FF..F, sum_sat=1.
  - Below -2^(nBits-1): sum=0x800..0, sum_sat=1.
  - Otherwise the total is truncated to nBits, sum_sat=0.
- clear:
  - Sets acc=0, cnt=0, sum_valid=0 and state=ACCUM. sum and sum_sat keep their old values.
  - A beat presented in the same cycle is dropped, not accumulated. prod_ready is still asserted in that cycle.
- rst_n low mid-accumulation or mid-HOLD: partial sum and pending result are discarded; the reset values apply.
- prod is ignored when prod_valid=0. The inputs carry no X-propagation requirement when invalid.

Decomposition:
- Shared package rls_pkg holds:
  - the state enum {ACCUM, HOLD};
  - the default NBITS=32;
  - the function clog2, used for the cnt width and the GuardBits check. Elaboration fails if GuardBits < clog2(VecLen).
- One sub-module, rls_sat_narrow: combinational narrowing from (nBits+GuardBits) to nBits with saturation and the sat flag. It is reused by later RLS stages.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with prod_valid=1 and prod=5 -> sum_valid=0, sum=0, sum_sat=0 throughout; prod_ready=1 in the first cycle after release.
- Basic sum: VecLen=4, prod 1,2,3,4 on consecutive cycles, sum_ready=0 -> one cycle after the 4th accept, sum=10, sum_sat=0, sum_valid=1; sum stays held and prod_ready=0 for 3 cycles; sum_ready=1 then gives sum_valid=0 on the next edge.
- Signed: prod -5,3,-7,2 -> sum=0xFFFFFFF9 (-7), sum_sat=0.
- Saturation: four beats of 0x7FFFFFFF -> sum=0x7FFFFFFF, sum_sat=1; four beats of 0x80000000 -> sum=0x80000000, sum_sat=1.
- Streaming: sum_ready tied 1, prod 1..8 with prod_valid continuous -> results 10 then 26; no prod_ready deassertion; sum_valid high for exactly 1 cycle each.
- Flush: accept 7 and 9, pulse clear together with a valid beat of 100, then send four beats of 1 -> sum=4. Repeat with rst_n=0 for one cycle in place of clear -> sum=4.
